// File: rtl/up_trace_pkg.sv
// Shared definitions for the up-bus trace monitor: state encoding,
// trigger mode codes and trace entry field layout {ts, wr, err, addr, data}.
package up_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_IMM     = 2'd0;
  localparam logic [1:0] TRIG_ADDR    = 2'd1;
  localparam logic [1:0] TRIG_ADDR_WR = 2'd2;
  localparam logic [1:0] TRIG_EXT     = 2'd3;

  function automatic int entry_w(input int ts_w, input int addr_w, input int data_w);
    return ts_w + 2 + addr_w + data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int err_bit(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int wr_bit(input int addr_w, input int data_w);
    return data_w + addr_w + 1;
  endfunction

  function automatic int ts_lsb(input int addr_w, input int data_w);
    return data_w + addr_w + 2;
  endfunction

endpackage

// File: rtl/up_trace_ram.sv
// Trace buffer storage: one write port, one read port with registered data.
module up_trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 82
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // capture write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // readout port, one cycle latency
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/up_trace_monitor.sv
// Logic-analyser style trace unit for the up register bus. Filtered bus
// transactions are written into a circular buffer with a timestamp; a
// trigger splits capture into pre- and post-trigger phases.
//
// state   | meaning
// IDLE    | not armed, readout allowed
// PRE     | armed, capturing, waiting for trigger
// POST    | triggered, capturing remaining post-trigger entries
// DONE    | capture finished, readout allowed, re-arm allowed
module up_trace_monitor
  import up_trace_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 64,
  parameter  int TS_W    = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = entry_w(TS_W, ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               arm,
  input  logic               stop,
  input  logic [1:0]         trig_mode,
  input  logic               trig_ext,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic [ADDR_W-1:0]  filt_base,
  input  logic [ADDR_W-1:0]  filt_mask,
  input  logic [PTR_W:0]     post_cnt,
  input  logic               rd_req,
  input  logic [PTR_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [1:0]         state,
  output logic [PTR_W:0]     count,
  output logic [PTR_W-1:0]   trig_pos,
  output logic               overflow
);

  localparam logic [PTR_W:0] FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] REM_ONE = (PTR_W + 1)'(1);

  trace_state_e       st;
  logic [TS_W-1:0]    ts;
  logic [PTR_W-1:0]   wptr, trig_ptr;
  logic [PTR_W:0]     remaining;
  logic               capture, trig_cond, trig_hit, rd_ok, rd_zero;
  logic [PTR_W-1:0]   wptr_nxt, oldest_nxt, oldest_ptr, trig_ptr_nxt, trig_pos_nxt;
  logic [PTR_W:0]     count_nxt;
  logic [ENTRY_W-1:0] wr_entry, ram_q;

  // capture qualification, trigger decode and post-write pointer view
  always_comb begin
    capture = ((st == ST_PRE) || (st == ST_POST)) && (wr_en || rd_en) &&
              ((addr_in & filt_mask) == (filt_base & filt_mask));
    case (trig_mode)
      TRIG_IMM:     trig_cond = 1'b1;
      TRIG_ADDR:    trig_cond = (addr_in == trig_addr);
      TRIG_ADDR_WR: trig_cond = (addr_in == trig_addr) && wr_en;
      default:      trig_cond = trig_ext;
    endcase
    trig_hit     = capture && (st == ST_PRE) && trig_cond;
    wptr_nxt     = capture ? wptr + 1'b1 : wptr;
    count_nxt    = (capture && (count != FULL)) ? count + 1'b1 : count;
    // trig_pos is taken relative to the buffer as it stands after this cycle's write
    oldest_nxt   = (count_nxt == FULL) ? wptr_nxt : '0;
    trig_ptr_nxt = trig_hit ? wptr : trig_ptr;
    trig_pos_nxt = trig_ptr_nxt - oldest_nxt;
    oldest_ptr   = (count == FULL) ? wptr : '0;
    rd_ok        = rd_req && ((st == ST_IDLE) || (st == ST_DONE));
    wr_entry     = {ts, wr_en, wr_en & rd_en, addr_in, data_in};
  end

  // capture sequencer: arm, trigger, post-trigger down-counter, stop
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      ts        <= '0;
      wptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      trig_ptr  <= '0;
      trig_pos  <= '0;
      remaining <= '0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            st       <= ST_PRE;
            ts       <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            trig_ptr <= '0;
            trig_pos <= '0;
          end
        end
        ST_PRE, ST_POST: begin
          ts       <= ts + 1'b1;
          wptr     <= wptr_nxt;
          count    <= count_nxt;
          trig_ptr <= trig_ptr_nxt;
          if (capture && (count == FULL)) overflow <= 1'b1;
          if (stop) begin
            st       <= ST_DONE;
            trig_pos <= (st == ST_PRE) ? '0 : trig_pos_nxt;
          end else if (trig_hit) begin
            remaining <= post_cnt;
            if (post_cnt == '0) begin
              st       <= ST_DONE;
              trig_pos <= trig_pos_nxt;
            end else begin
              st <= ST_POST;
            end
          end else if ((st == ST_POST) && capture) begin
            remaining <= remaining - 1'b1;
            if (remaining == REM_ONE) begin
              st       <= ST_DONE;
              trig_pos <= trig_pos_nxt;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // readout handshake; out-of-range indices read back as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_ok;
      rd_zero  <= ({1'b0, rd_idx} >= count);
    end
  end

  assign rd_entry = (rd_valid && !rd_zero) ? ram_q : '0;
  assign state    = st;

  up_trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_ram (
    .clk  (clk),
    .we   (capture),
    .waddr(wptr),
    .wdata(wr_entry),
    .re   (rd_ok),
    .raddr(oldest_ptr + rd_idx),
    .rdata(ram_q)
  );

endmodule
